// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit.
// Holds the 3-bit op encodings used by both the instruction decoder and
// mult_div_unit, and the unit's two-state control encoding.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the pipeline and mult_div_unit.
//   SrcA, SrcB : operands rs / rt
//   op, start  : operation code, qualified by a one-cycle start
//   busy       : operation in flight (registered)
//   HI, LO     : architectural HI/LO registers, read by the MFHI/MFLO selector
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output SrcA, SrcB, op, start, input busy, HI, LO);
  modport slave  (input SrcA, SrcB, op, start, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when a request is accepted, parked in pending
// registers and only copied to HI/LO on the edge that ends the busy period,
// so HI/LO never show a result early.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   md    : mult_div_if slave (SrcA, SrcB, op, start -> busy, HI, LO)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave md
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [2*WIDTH-1:0] prod, divres;

  // Full-width product; sign/zero extension to 2*WIDTH first makes the
  // truncated 2*WIDTH product correct for both signed and unsigned.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so it
  // truncates toward zero, the remainder follows the dividend, and
  // MIN_INT / -1 wraps naturally to MIN_INT with remainder 0.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] ua, ub, q, r;
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ua    = neg_a ? -a : a;
    ub    = neg_b ? -b : b;
    q     = (ub == '0) ? '0 : ua / ub;
    r     = (ub == '0) ? '0 : ua % ub;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a)         r = -r;
    return {r, q};
  endfunction

  assign prod   = mul_full(md.SrcA, md.SrcB, md.op == MD_MULT);
  assign divres = div_full(md.SrcA, md.SrcB, md.op == MD_DIV);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          case (md.op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = prod[2*WIDTH-1:WIDTH];
              pend_lo_d = prod[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = MD_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = divres[2*WIDTH-1:WIDTH];
              pend_lo_d = divres[WIDTH-1:0];
              // Divide by zero still burns the full busy period, but writes nothing.
              pend_wr_d = (md.SrcB != '0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = MD_BUSY;
            end
            MD_MTHI: hi_d = md.SrcA;
            MD_MTLO: lo_d = md.SrcA;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        // Last busy cycle: commit pending result and drop busy together.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Pending operands are pure data; pend_wr_q gates whether they are used.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign md.busy = (state_q == MD_BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized traffic, every
// cycle compared against a cycle-level behavioural model of HI/LO/busy.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) md_if ();

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  // Reference model state
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_left;
  bit           m_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit st, input logic [2:0] o,
                            input logic [W-1:0] a, input logic [W-1:0] b, input bit rs);
    logic [63:0] pr;
    longint      sa, sb, q, r;
    if (rs) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_wr = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (st) begin
      case (o)
        MD_MULT: begin
          pr = 64'(longint'($signed(a)) * longint'($signed(b)));
          p_hi = pr[63:32]; p_lo = pr[31:0]; m_wr = 1; m_left = MC;
        end
        MD_MULTU: begin
          pr = {32'b0, a} * {32'b0, b};
          p_hi = pr[63:32]; p_lo = pr[31:0]; m_wr = 1; m_left = MC;
        end
        MD_DIV: begin
          m_left = DC; m_wr = (b != 0);
          if (b != 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
        end
        MD_DIVU: begin
          m_left = DC; m_wr = (b != 0);
          if (b != 0) begin
            p_lo = a / b; p_hi = a % b;
          end
        end
        MD_MTHI: m_hi = a;
        MD_MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1 ns later.
  task automatic cycle(input bit st, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit rs);
    md_if.start = st; md_if.op = o; md_if.SrcA = a; md_if.SrcB = b; reset = rs;
    @(posedge clk);
    model_step(st, o, a, b, rs);
    #1;
    chk("busy", {63'b0, md_if.busy}, {63'b0, (m_left > 0)});
    chk("hi", {32'b0, md_if.HI}, {32'b0, m_hi});
    chk("lo", {32'b0, md_if.LO}, {32'b0, m_lo});
    if (md_if.busy) busy_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, MD_NONE, '0, '0, 0);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] sv_hi, sv_lo;

  initial begin
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0; m_wr = 0;
    busy_cnt = 0;

    // Reset state
    cycle(0, MD_NONE, '0, '0, 1);
    cycle(0, MD_NONE, '0, '0, 1);
    chk("rst_busy", {63'b0, md_if.busy}, 64'd0);
    chk("rst_hi", {32'b0, md_if.HI}, 64'd0);

    // MULT -3 * 7
    busy_cnt = 0;
    cycle(1, MD_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    idle(MC);
    chk("mult_busy_len", 64'(busy_cnt), 64'(MC));
    chk("mult_hi", {32'b0, md_if.HI}, {32'b0, 32'hFFFF_FFFF});
    chk("mult_lo", {32'b0, md_if.LO}, {32'b0, 32'hFFFF_FFEB});

    // MULTU 0xFFFFFFFF * 2
    cycle(1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    idle(MC);
    chk("multu_hi", {32'b0, md_if.HI}, 64'h1);
    chk("multu_lo", {32'b0, md_if.LO}, {32'b0, 32'hFFFF_FFFE});

    // DIV -7 / 2
    busy_cnt = 0;
    cycle(1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    idle(DC);
    chk("div_busy_len", 64'(busy_cnt), 64'(DC));
    chk("div_lo", {32'b0, md_if.LO}, {32'b0, 32'hFFFF_FFFD});
    chk("div_hi", {32'b0, md_if.HI}, {32'b0, 32'hFFFF_FFFF});

    // DIVU 7 / 0: full busy period, HI/LO untouched
    sv_hi = md_if.HI; sv_lo = md_if.LO; busy_cnt = 0;
    cycle(1, MD_DIVU, 32'd7, 32'd0, 0);
    idle(DC);
    chk("div0_busy_len", 64'(busy_cnt), 64'(DC));
    chk("div0_hi", {32'b0, md_if.HI}, {32'b0, sv_hi});
    chk("div0_lo", {32'b0, md_if.LO}, {32'b0, sv_lo});

    // MTHI while idle: zero latency, busy stays low
    cycle(1, MD_MTHI, 32'h1234_5678, '0, 0);
    chk("mthi_hi", {32'b0, md_if.HI}, {32'b0, 32'h1234_5678});
    chk("mthi_busy", {63'b0, md_if.busy}, 64'd0);

    // MTLO during busy is ignored
    cycle(1, MD_DIVU, 32'd100, 32'd7, 0);
    cycle(1, MD_MTLO, 32'hDEAD_BEEF, '0, 0);
    idle(DC - 1);
    chk("mtlo_ignored_lo", {32'b0, md_if.LO}, 64'd14);
    chk("mtlo_ignored_hi", {32'b0, md_if.HI}, 64'd2);

    // MIN_INT / -1
    cycle(1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(DC);
    chk("minint_lo", {32'b0, md_if.LO}, {32'b0, 32'h8000_0000});
    chk("minint_hi", {32'b0, md_if.HI}, 64'd0);

    // Back-to-back: DIV then MULT in the cycle busy falls
    cycle(1, MD_DIVU, 32'd50, 32'd6, 0);
    idle(DC);
    chk("b2b_div_lo", {32'b0, md_if.LO}, 64'd8);
    chk("b2b_idle", {63'b0, md_if.busy}, 64'd0);
    cycle(1, MD_MULT, 32'd6, 32'hFFFF_FFFE, 0);
    chk("b2b_accept", {63'b0, md_if.busy}, 64'd1);
    idle(MC);
    chk("b2b_mult_lo", {32'b0, md_if.LO}, {32'b0, 32'hFFFF_FFF4});

    // Reset in cycle 3 of a DIV aborts it
    cycle(1, MD_DIV, 32'd99, 32'd3, 0);
    idle(2);
    cycle(0, MD_NONE, '0, '0, 1);
    chk("rst_mid_busy", {63'b0, md_if.busy}, 64'd0);
    chk("rst_mid_lo", {32'b0, md_if.LO}, 64'd0);
    idle(DC);
    chk("rst_mid_nowrite", {32'b0, md_if.LO}, 64'd0);

    // Reset wins over start on the same edge
    cycle(1, MD_MTHI, 32'hAAAA_5555, '0, 1);
    chk("rst_prio_hi", {32'b0, md_if.HI}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            rand_opnd(), rand_opnd(), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
